// File: rtl/artemis_clk_pkg.sv
// Shared types and defaults for the Artemis PLL reset/lock sequencer.
package artemis_clk_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      DDR_REL   = 3'd3,
      RUN       = 3'd4,
      FAIL      = 3'd5
   } state_e;

   localparam int DEF_PLL_RST_CYCLES = 16;
   localparam int DEF_LOCK_TIMEOUT   = 100000;
   localparam int DEF_STABLE_CYCLES  = 1024;
   localparam int DEF_DDR_RST_DELAY  = 64;
   localparam int DEF_MAX_RETRY      = 7;

   // Width of the shared down-counter: enough bits for the largest load value.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/artemis_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit, reset value 0.
module artemis_sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back capture flops; the first may go metastable.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/artemis_clk_rst_seq.sv
// PLL reset / lock sequencer: pulses the PLL reset, waits for a stable lock
// with timeout and bounded retries, then releases DDR3 and system resets in order.
module artemis_clk_rst_seq
   import artemis_clk_pkg::*;
#(
   parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int DDR_RST_DELAY  = DEF_DDR_RST_DELAY,
   parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       restart,
   output logic       pll_rst,
   output logic       ddr3_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fail,
   output logic       lock_lost,
   output logic [3:0] retry_cnt
);

   localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, DDR_RST_DELAY);

   // A state with load value N-1 lasts N cycles. Reset loads one extra count so
   // that the first cycle after rst release still shows the freshly loaded value.
   localparam logic [CW-1:0] LD_RST     = CW'(PLL_RST_CYCLES);
   localparam logic [CW-1:0] LD_PLL_RST = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] LD_WAIT    = CW'(LOCK_TIMEOUT - 1);
   // The locked sample that moves WAIT_LOCK to STABLE is the first of the window.
   localparam logic [CW-1:0] LD_STABLE  = CW'(STABLE_CYCLES - 2);
   localparam logic [CW-1:0] LD_DDR     = CW'(DDR_RST_DELAY - 1);
   localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRY);

   logic          locked_s;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    retry_q, retry_d, retry_inc;
   logic          lock_lost_q, lock_lost_d;
   logic          pll_rst_q, pll_rst_d;
   logic          ddr3_rst_q, ddr3_rst_d;
   logic          sys_rst_q, sys_rst_d;
   logic          ready_q, ready_d;
   logic          fail_q, fail_d;

   artemis_sync_2ff u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d_i (pll_locked),
      .q_o (locked_s)
   );

   // Next state, counter, retry and output decode; restart beats lock loss beats timer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      retry_d     = retry_q;
      lock_lost_d = lock_lost_q;
      retry_inc   = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

      if (restart) begin
         state_d = PLL_RST;
         cnt_d   = LD_PLL_RST;
         retry_d = 4'd0;
      end else begin
         case (state_q)
            PLL_RST: begin
               if (cnt_q == '0) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = LD_WAIT;
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state_d = STABLE;
                  cnt_d   = LD_STABLE;
               end else if (cnt_q == '0) begin
                  retry_d = retry_inc;
                  if (retry_inc == RETRY_MAX) begin
                     state_d = FAIL;
                  end else begin
                     state_d = PLL_RST;
                     cnt_d   = LD_PLL_RST;
                  end
               end
            end
            STABLE: begin
               if (!locked_s) begin
                  state_d = PLL_RST;
                  cnt_d   = LD_PLL_RST;
               end else if (cnt_q == '0) begin
                  state_d = DDR_REL;
                  cnt_d   = LD_DDR;
               end
            end
            DDR_REL: begin
               if (!locked_s) begin
                  state_d = PLL_RST;
                  cnt_d   = LD_PLL_RST;
               end else if (cnt_q == '0) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (!locked_s) begin
                  state_d     = PLL_RST;
                  cnt_d       = LD_PLL_RST;
                  lock_lost_d = 1'b1;
               end
            end
            FAIL: begin
               state_d = FAIL;
            end
            default: begin
               state_d = PLL_RST;
               cnt_d   = LD_PLL_RST;
            end
         endcase
      end

      pll_rst_d  = (state_d == PLL_RST) || (state_d == FAIL);
      ddr3_rst_d = !((state_d == DDR_REL) || (state_d == RUN));
      sys_rst_d  = (state_d != RUN);
      ready_d    = (state_d == RUN);
      fail_d     = (state_d == FAIL);
   end

   // State, counter and registered outputs; rst forces the PLL_RST entry values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= PLL_RST;
         cnt_q       <= LD_RST;
         retry_q     <= 4'd0;
         lock_lost_q <= 1'b0;
         pll_rst_q   <= 1'b1;
         ddr3_rst_q  <= 1'b1;
         sys_rst_q   <= 1'b1;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         lock_lost_q <= lock_lost_d;
         pll_rst_q   <= pll_rst_d;
         ddr3_rst_q  <= ddr3_rst_d;
         sys_rst_q   <= sys_rst_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
      end
   end

   assign pll_rst   = pll_rst_q;
   assign ddr3_rst  = ddr3_rst_q;
   assign sys_rst   = sys_rst_q;
   assign ready     = ready_q;
   assign fail      = fail_q;
   assign lock_lost = lock_lost_q;
   assign retry_cnt = retry_q;

endmodule
